systolic_array_ctrl: RTL and testbench
======================================

SYSTOLIC_ARRAY_CTRL -- requirements
Module: systolic_array_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 8, number of mesh rows (>=2).
REQ-002 SHALL have parameter COLS, default 8, number of mesh columns (>=2), independent of ROWS.
REQ-003 SHALL have parameter K_MAX, default 64, maximum inner-dimension length per multiply.
REQ-004 SHALL have parameter DATA_WIDTH, default 32, accumulator and result width.
REQ-005 SHALL have these ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  start pulse.
- k_len_i  in  $clog2(K_MAX+1)  inner length, sampled on accepted start.
- abort_i  in  1  abandon operation.
- mesh_done_i  in  1  mesh compute complete.
- acc_col_i  in  ROWS*DATA_WIDTH  selected column's accumulators; row r at bits [r*DATA_WIDTH +: DATA_WIDTH].
- res_ready_i  in  1  result sink ready.
- busy_o  out  1  high in any state except IDLE.
- mesh_clear_o  out  1  accumulator clear pulse.
- feed_en_o  out  1  queue advance enable.
- feed_last_o  out  1  final feed beat.
- select_col_o  out  COLS  one-hot drain column select.
- res_valid_o  out  1  result valid.
- res_data_o  out  DATA_WIDTH  result element.
- res_row_o  out  $clog2(ROWS)  element row index.
- res_col_o  out  $clog2(COLS)  element column index.
- res_last_o  out  1  final element of matrix.
- done_o  out  1  completion pulse.
- err_o  out  1  error pulse.

Function
REQ-006 SHALL implement FSM states IDLE, CLEAR, FEED, WAIT, DRAIN_SEL, DRAIN_OUT, DONE; all outputs registered.
REQ-007 IDLE: start_i with 1<=k_len_i<=K_MAX -> CLEAR; start_i with k_len_i==0 or >K_MAX -> err_o one-cycle pulse, remain IDLE.
REQ-008 start_i outside IDLE SHALL be ignored, no side effects.
REQ-009 CLEAR: mesh_clear_o high exactly one cycle, then FEED.
REQ-010 FEED: feed_en_o high exactly k_len cycles; feed_last_o high only on the last; then WAIT.
REQ-011 WAIT: remain until mesh_done_i high, then DRAIN_SEL with column index COLS-1; mesh_done_i outside WAIT ignored.
REQ-012 DRAIN_SEL: select_col_o one-hot at current column, zero in all other states; acc_col_i captured into internal ROWS-entry buffer at end of this single cycle; then DRAIN_OUT with row 0.
REQ-013 DRAIN_OUT: res_valid_o high; res_data_o/res_row_o/res_col_o from buffer; held stable until res_valid_o&&res_ready_i.
REQ-014 On handshake: row<ROWS-1 -> row+1 next cycle (one element per cycle at full throughput); row==ROWS-1 and column>0 -> DRAIN_SEL with column-1; row==ROWS-1 and column==0 -> DONE.
REQ-015 Drain order SHALL be column COLS-1 down to 0, row 0 up to ROWS-1 within a column; exactly ROWS*COLS handshakes per operation.
REQ-016 res_last_o high only with row ROWS-1, column 0.
REQ-017 DONE: done_o one-cycle pulse, then IDLE; start_i may be accepted the cycle after DONE.
REQ-018 abort_i high in any non-IDLE state SHALL force IDLE next cycle, deassert res_valid_o/feed_en_o/select_col_o, and emit no done_o; abort_i has priority over every other transition.

Reset
REQ-019 rstn_i low SHALL asynchronously force IDLE, counters and buffer to 0, every output to 0.
REQ-020 Reset mid-operation SHALL discard all progress; no done_o after release.

Configuration
REQ-021 With SA_CTRL_WATCHDOG_EN defined: counter in WAIT; if mesh_done_i absent for ROWS+COLS+K_MAX cycles -> err_o one-cycle pulse, state IDLE, no done_o; counter cleared on entering WAIT.
REQ-022 Without SA_CTRL_WATCHDOG_EN: no counter logic; WAIT waits indefinitely; err_o only from REQ-007.

Verification
REQ-023 ROWS=4, COLS=3, k_len=5, mesh_done_i 7 cycles after feed_last_o, res_ready_i=1 -> 1 clear, 5 feed beats, 12 results order (c2,r0..r3),(c1..),(c0..), res_last_o on 12th, done_o once.
REQ-024 Same config, res_ready_i toggling 1/0 -> data/indices stable during stalls, sequence identical, done_o after 12th handshake.
REQ-025 start_i with k_len_i=0 -> err_o pulse, busy_o stays 0; start_i during FEED -> feed beat count unchanged.
REQ-026 abort_i asserted on 5th result -> IDLE next cycle, res_valid_o=0, no done_o; new start completes normally.
REQ-027 rstn_i low during DRAIN_OUT -> all outputs 0 immediately, IDLE after release.
REQ-028 SA_CTRL_WATCHDOG_EN defined, ROWS=4, COLS=3, K_MAX=8, mesh_done_i never asserted -> err_o exactly 15 cycles after WAIT entry, IDLE.

Source files
------------

// File: rtl/systolic_array_ctrl.sv
// Sequencer for a ROWS x COLS systolic mesh: clear, feed k_len beats, wait for the mesh, drain column by column.
// Optional WAIT-state watchdog enabled by defining SA_CTRL_WATCHDOG_EN.
module systolic_array_ctrl #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int K_MAX      = 64,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       start_i,
  input  logic [$clog2(K_MAX+1)-1:0] k_len_i,
  input  logic                       abort_i,
  input  logic                       mesh_done_i,
  input  logic [ROWS*DATA_WIDTH-1:0] acc_col_i,
  input  logic                       res_ready_i,
  output logic                       busy_o,
  output logic                       mesh_clear_o,
  output logic                       feed_en_o,
  output logic                       feed_last_o,
  output logic [COLS-1:0]            select_col_o,
  output logic                       res_valid_o,
  output logic [DATA_WIDTH-1:0]      res_data_o,
  output logic [$clog2(ROWS)-1:0]    res_row_o,
  output logic [$clog2(COLS)-1:0]    res_col_o,
  output logic                       res_last_o,
  output logic                       done_o,
  output logic                       err_o
);
  // state      | meaning
  // S_IDLE     | waiting for a valid start
  // S_CLEAR    | one-cycle accumulator clear
  // S_FEED     | k_len feed beats
  // S_WAIT     | waiting for mesh_done_i
  // S_DRAIN_SEL| select column, capture its accumulators
  // S_DRAIN_OUT| stream captured column, one row per handshake
  // S_DONE     | completion pulse

  localparam int KW = $clog2(K_MAX+1);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [KW-1:0] K_MAX_L  = KW'(K_MAX);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS-1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS-1);
`ifdef SA_CTRL_WATCHDOG_EN
  localparam int WD_CYC = ROWS + COLS + K_MAX;
  localparam int WW     = $clog2(WD_CYC);
  localparam logic [WW-1:0] WD_INIT = WW'(WD_CYC-1);
  logic [WW-1:0] wd_q, wd_d;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_WAIT, S_DRAIN_SEL, S_DRAIN_OUT, S_DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [KW-1:0]              cnt_q, cnt_d;
  logic [RW-1:0]              row_q, row_d;
  logic [CW-1:0]              col_q, col_d;
  logic [ROWS*DATA_WIDTH-1:0] buf_q, buf_d;

  logic                  busy_q, busy_d, clear_q, clear_d, feed_en_q, feed_en_d;
  logic                  feed_last_q, feed_last_d, res_valid_q, res_valid_d;
  logic                  res_last_q, res_last_d, done_q, done_d, err_q, err_d;
  logic [COLS-1:0]       sel_q, sel_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic [RW-1:0]         res_row_q, res_row_d;
  logic [CW-1:0]         res_col_q, res_col_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    buf_d   = buf_q;
    err_d   = 1'b0;
`ifdef SA_CTRL_WATCHDOG_EN
    wd_d    = wd_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (k_len_i != '0 && k_len_i <= K_MAX_L) begin
            state_d = S_CLEAR;
            cnt_d   = k_len_i - KW'(1);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CLEAR: state_d = S_FEED;
      S_FEED: begin
        if (cnt_q == '0) begin
          state_d = S_WAIT;
`ifdef SA_CTRL_WATCHDOG_EN
          wd_d    = WD_INIT;
`endif
        end else begin
          cnt_d = cnt_q - KW'(1);
        end
      end
      S_WAIT: begin
        if (mesh_done_i) begin
          state_d = S_DRAIN_SEL;
          col_d   = COL_LAST;
        end
`ifdef SA_CTRL_WATCHDOG_EN
        else if (wd_q == '0) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q - WW'(1);
        end
`endif
      end
      S_DRAIN_SEL: begin
        buf_d   = acc_col_i;
        row_d   = '0;
        state_d = S_DRAIN_OUT;
      end
      S_DRAIN_OUT: begin
        if (res_valid_q && res_ready_i) begin
          if (row_q != ROW_LAST) begin
            row_d = row_q + RW'(1);
          end else if (col_q != '0) begin
            col_d   = col_q - CW'(1);
            state_d = S_DRAIN_SEL;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort outranks every transition, including the watchdog error.
    if (abort_i && state_q != S_IDLE) begin
      state_d = S_IDLE;
      err_d   = 1'b0;
    end

    busy_d      = (state_d != S_IDLE);
    clear_d     = (state_d == S_CLEAR);
    feed_en_d   = (state_d == S_FEED);
    feed_last_d = (state_d == S_FEED) && (cnt_d == '0);
    sel_d       = (state_d == S_DRAIN_SEL) ? (COLS'(1) << col_d) : '0;
    res_valid_d = (state_d == S_DRAIN_OUT);
    res_data_d  = res_valid_d ? buf_d[row_d*DATA_WIDTH +: DATA_WIDTH] : '0;
    res_row_d   = res_valid_d ? row_d : '0;
    res_col_d   = res_valid_d ? col_d : '0;
    res_last_d  = res_valid_d && (row_d == ROW_LAST) && (col_d == '0);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      buf_q       <= '0;
      busy_q      <= 1'b0;
      clear_q     <= 1'b0;
      feed_en_q   <= 1'b0;
      feed_last_q <= 1'b0;
      sel_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_row_q   <= '0;
      res_col_q   <= '0;
      res_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef SA_CTRL_WATCHDOG_EN
      wd_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      buf_q       <= buf_d;
      busy_q      <= busy_d;
      clear_q     <= clear_d;
      feed_en_q   <= feed_en_d;
      feed_last_q <= feed_last_d;
      sel_q       <= sel_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_row_q   <= res_row_d;
      res_col_q   <= res_col_d;
      res_last_q  <= res_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef SA_CTRL_WATCHDOG_EN
      wd_q        <= wd_d;
`endif
    end
  end

  assign busy_o       = busy_q;
  assign mesh_clear_o = clear_q;
  assign feed_en_o    = feed_en_q;
  assign feed_last_o  = feed_last_q;
  assign select_col_o = sel_q;
  assign res_valid_o  = res_valid_q;
  assign res_data_o   = res_data_q;
  assign res_row_o    = res_row_q;
  assign res_col_o    = res_col_q;
  assign res_last_o   = res_last_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Randomized bench for systolic_array_ctrl; expected drain order and data come from a per-operation matrix.
module tb_systolic_array_ctrl;
  localparam int ROWS = 4;
  localparam int COLS = 3;
  localparam int K_MAX = 8;
  localparam int DW = 16;
  localparam int KW = $clog2(K_MAX+1);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic clk_i = 1'b0;
  logic rstn_i, start_i, abort_i, mesh_done_i, res_ready_i;
  logic [KW-1:0] k_len_i;
  logic [ROWS*DW-1:0] acc_col_i, noise;
  logic busy_o, mesh_clear_o, feed_en_o, feed_last_o, res_valid_o, res_last_o, done_o, err_o;
  logic [COLS-1:0] select_col_o;
  logic [DW-1:0] res_data_o;
  logic [RW-1:0] res_row_o;
  logic [CW-1:0] res_col_o;

  logic [DW-1:0] mat [ROWS][COLS];
  int n_chk = 0;
  int n_err = 0;

  systolic_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .k_len_i(k_len_i),
    .abort_i(abort_i), .mesh_done_i(mesh_done_i), .acc_col_i(acc_col_i),
    .res_ready_i(res_ready_i), .busy_o(busy_o), .mesh_clear_o(mesh_clear_o),
    .feed_en_o(feed_en_o), .feed_last_o(feed_last_o), .select_col_o(select_col_o),
    .res_valid_o(res_valid_o), .res_data_o(res_data_o), .res_row_o(res_row_o),
    .res_col_o(res_col_o), .res_last_o(res_last_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // The mesh presents the selected column of the current matrix; anything else reads as noise.
  always_comb begin
    acc_col_i = noise;
    for (int c = 0; c < COLS; c++)
      if (select_col_o[c])
        for (int r = 0; r < ROWS; r++) acc_col_i[r*DW +: DW] = mat[r][c];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    noise = {$urandom, $urandom};
  endtask

  function automatic logic [63:0] all_outs();
    return {busy_o, mesh_clear_o, feed_en_o, feed_last_o, select_col_o, res_valid_o,
            res_data_o, res_row_o, res_col_o, res_last_o, done_o, err_o};
  endfunction

  // rmode: 0 ready always, 1 toggling, 2 random. abort_at: result number (1-based) to abort on, 0 none.
  task automatic run_op(input int k, input int rmode, input int delay, input int abort_at,
                        input bit start_in_feed);
    int clears, feeds, lasts, last_beat, nres, dones, errs, last_cyc, ec, er;
    bit prev_stall, fin;
    logic [DW-1:0] pd;
    logic [RW-1:0] pr;
    logic [CW-1:0] pc;
    clears = 0; feeds = 0; lasts = 0; last_beat = 0; nres = 0; dones = 0; errs = 0;
    last_cyc = -1000; prev_stall = 0; fin = 0; pd = '0; pr = '0; pc = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mat[r][c] = DW'($urandom);
    start_i = 1'b1;
    k_len_i = KW'(k);
    tick();
    start_i = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (err_o) errs++;
      if (mesh_clear_o) clears++;
      if (feed_en_o) begin
        feeds++;
        if (feed_last_o) begin
          lasts++;
          last_beat = feeds;
          last_cyc  = cyc;
        end
      end else if (feed_last_o) begin
        chk("feed_last_without_en", 1, 0);
      end
      if (prev_stall) begin
        chk("stall_valid", res_valid_o, 1);
        chk("stall_data", res_data_o, pd);
        chk("stall_row", res_row_o, pr);
        chk("stall_col", res_col_o, pc);
      end
      if (done_o) begin
        dones++;
        chk("done_after_last", nres, ROWS*COLS);
        fin = 1;
      end
      start_i     = start_in_feed && feed_en_o && (feeds == 2);
      k_len_i     = KW'(3);
      mesh_done_i = (feed_en_o && feeds == 1) || (cyc == last_cyc + delay) ||
                    (res_valid_o && $urandom_range(0, 1) == 1);
      case (rmode)
        0:       res_ready_i = 1'b1;
        1:       res_ready_i = (cyc % 2 == 0);
        default: res_ready_i = ($urandom_range(0, 1) == 1);
      endcase
      prev_stall = res_valid_o && !res_ready_i;
      pd = res_data_o; pr = res_row_o; pc = res_col_o;
      if (res_valid_o && abort_at != 0 && nres == abort_at - 1) begin
        abort_i = 1'b1;
        start_i = 1'b0;
        mesh_done_i = 1'b0;
        tick();
        abort_i = 1'b0;
        res_ready_i = 1'b0;
        chk("abort_valid", res_valid_o, 0);
        chk("abort_busy", busy_o, 0);
        for (int i = 0; i < 20; i++) begin
          if (done_o) dones++;
          tick();
        end
        chk("abort_no_done", dones, 0);
        return;
      end
      if (res_valid_o && res_ready_i) begin
        ec = COLS - 1 - nres / ROWS;
        er = nres % ROWS;
        chk("res_data", res_data_o, mat[er][ec]);
        chk("res_row", res_row_o, er);
        chk("res_col", res_col_o, ec);
        chk("res_last", res_last_o, (nres == ROWS*COLS - 1));
        nres++;
      end
      tick();
    end
    start_i = 1'b0; mesh_done_i = 1'b0; res_ready_i = 1'b0;
    chk("op_finished", fin, 1);
    chk("clear_count", clears, 1);
    chk("feed_count", feeds, k);
    chk("feed_last_count", lasts, 1);
    chk("feed_last_beat", last_beat, k);
    chk("result_count", nres, ROWS*COLS);
    chk("done_count", dones, 1);
    chk("err_during_op", errs, 0);
    chk("done_pulse", done_o, 0);
    chk("idle_after_done", busy_o, 0);
  endtask

  task automatic bad_start(input int k);
    start_i = 1'b1;
    k_len_i = KW'(k);
    tick();
    start_i = 1'b0;
    chk("bad_start_err", err_o, 1);
    chk("bad_start_busy", busy_o, 0);
    tick();
    chk("bad_start_err_pulse", err_o, 0);
    chk("bad_start_still_idle", busy_o, 0);
  endtask

  initial begin
    int dones, seen;
    rstn_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; mesh_done_i = 1'b0;
    res_ready_i = 1'b0; k_len_i = '0; noise = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mat[r][c] = '0;
    #23;
    chk("reset_outputs", all_outs(), 0);
    rstn_i = 1'b1;
    tick();
    chk("post_reset_idle", busy_o, 0);

    run_op(5, 0, 7, 0, 0);
    run_op(5, 1, 7, 0, 0);
    bad_start(0);
    bad_start(K_MAX + 1);
    run_op(5, 0, 3, 0, 1);
    run_op(4, 2, 5, 5, 0);
    run_op(3, 0, 2, 0, 0);

    // Asynchronous reset while a result is being presented.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mat[r][c] = DW'($urandom) | DW'(1);
    start_i = 1'b1; k_len_i = KW'(2);
    tick();
    start_i = 1'b0; mesh_done_i = 1'b1; res_ready_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 60 && seen == 0; i++) begin
      if (res_valid_o) seen = 1;
      else tick();
    end
    chk("reached_drain", seen, 1);
    mesh_done_i = 1'b0;
    #2 rstn_i = 1'b0;
    #1 chk("reset_mid_drain_outputs", all_outs(), 0);
    tick();
    rstn_i = 1'b1;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done_o || busy_o) dones++;
    end
    chk("reset_discards_progress", dones, 0);
    run_op(1, 2, 1, 0, 0);

    run_op(1, 0, 1, 0, 0);
    run_op(K_MAX, 1, 10, 0, 0);
    for (int i = 0; i < 6; i++)
      run_op($urandom_range(1, K_MAX), $urandom_range(0, 2), $urandom_range(1, 10), 0,
             $urandom_range(0, 1) == 1);

`ifdef SA_CTRL_WATCHDOG_EN
    begin
      int entry, errcyc;
      entry = -1; errcyc = -1;
      start_i = 1'b1; k_len_i = KW'(2);
      tick();
      start_i = 1'b0;
      for (int cyc = 0; cyc < 100 && errcyc < 0; cyc++) begin
        if (feed_last_o) entry = cyc + 1;
        if (err_o) begin
          errcyc = cyc;
          chk("wd_idle", busy_o, 0);
          chk("wd_no_done", done_o, 0);
        end
        tick();
      end
      chk("wd_latency", errcyc - entry, ROWS + COLS + K_MAX);
      chk("wd_err_pulse", err_o, 0);
    end
`else
    run_op(2, 0, 40, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
